// File: rtl/perf_csr_unit.sv
// Machine performance counters (mcycle, minstret, mcountinhibit) with a registered CSR port.
// Optional PERF_STALL_CNT_EN adds mhpmcounter3 counting pipeline stall cycles.
module perf_csr_unit #(
  parameter logic [63:0] CYCLE_RST   = 64'h0,
  parameter logic [63:0] INSTRET_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic        stall_cycle,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  input  logic        csr_kill,
  output logic        csr_rsp_valid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal
);

`ifdef PERF_STALL_CNT_EN
  localparam logic [31:0] INH_MASK = 32'h0000_000D;
`else
  localparam logic [31:0] INH_MASK = 32'h0000_0005;
`endif

  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] inh_q, inh_d;
  logic        rsp_valid_q, rsp_valid_d, illegal_q, illegal_d;
  logic [31:0] rdata_q, rdata_d;

  logic        acc, mapped, ro, do_wr, illegal, wr_en;
  logic        sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi, sel_inh;
  logic        sel_hpm_lo, sel_hpm_hi;
  logic [31:0] rval, wval;

`ifdef PERF_STALL_CNT_EN
  logic [63:0] hpm3_q, hpm3_d;
`else
  logic unused_stall;
  assign unused_stall = stall_cycle;
`endif

  always_comb begin
    acc        = csr_req & ~csr_kill;
    mapped     = 1'b1;
    ro         = (csr_addr[11:8] == 4'hC);
    rval       = 32'h0;
    sel_cyc_lo = 1'b0;
    sel_cyc_hi = 1'b0;
    sel_ins_lo = 1'b0;
    sel_ins_hi = 1'b0;
    sel_inh    = 1'b0;
    sel_hpm_lo = 1'b0;
    sel_hpm_hi = 1'b0;
    case (csr_addr)
      12'hB00, 12'hC00: begin rval = mcycle_q[31:0];    sel_cyc_lo = 1'b1; end
      12'hB80, 12'hC80: begin rval = mcycle_q[63:32];   sel_cyc_hi = 1'b1; end
      12'hB02, 12'hC02: begin rval = minstret_q[31:0];  sel_ins_lo = 1'b1; end
      12'hB82, 12'hC82: begin rval = minstret_q[63:32]; sel_ins_hi = 1'b1; end
      12'h320:          begin rval = inh_q;             sel_inh    = 1'b1; end
`ifdef PERF_STALL_CNT_EN
      12'hB03, 12'hC03: begin rval = hpm3_q[31:0];      sel_hpm_lo = 1'b1; end
      12'hB83, 12'hC83: begin rval = hpm3_q[63:32];     sel_hpm_hi = 1'b1; end
`else
      // Absent counter: reads zero, writes are silently dropped, never faults.
      12'hB03, 12'hC03, 12'hB83, 12'hC83: ro = 1'b0;
`endif
      default: mapped = 1'b0;
    endcase

    // set/clear with a zero mask is a pure read, so it may target RO aliases.
    do_wr   = (csr_op == 2'b01) | (csr_op[1] & (|csr_wdata));
    illegal = ~mapped | (ro & do_wr);
    wr_en   = acc & do_wr & ~illegal;

    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = rval | csr_wdata;
      default: wval = rval & ~csr_wdata;
    endcase

    // A write to either half freezes the whole counter for that cycle.
    mcycle_d = mcycle_q;
    if (wr_en & sel_cyc_lo)      mcycle_d[31:0]  = wval;
    else if (wr_en & sel_cyc_hi) mcycle_d[63:32] = wval;
    else if (!inh_q[0])          mcycle_d        = mcycle_q + 64'd1;

    minstret_d = minstret_q;
    if (wr_en & sel_ins_lo)              minstret_d[31:0]  = wval;
    else if (wr_en & sel_ins_hi)         minstret_d[63:32] = wval;
    else if (retire_valid && !inh_q[2])  minstret_d        = minstret_q + 64'd1;

`ifdef PERF_STALL_CNT_EN
    hpm3_d = hpm3_q;
    if (wr_en & sel_hpm_lo)             hpm3_d[31:0]  = wval;
    else if (wr_en & sel_hpm_hi)        hpm3_d[63:32] = wval;
    else if (stall_cycle && !inh_q[3])  hpm3_d        = hpm3_q + 64'd1;
`endif

    inh_d       = (wr_en & sel_inh) ? (wval & INH_MASK) : inh_q;
    rsp_valid_d = acc;
    rdata_d     = (acc & ~illegal) ? rval : 32'h0;
    illegal_d   = acc & illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q    <= CYCLE_RST;
      minstret_q  <= INSTRET_RST;
      inh_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      illegal_q   <= 1'b0;
`ifdef PERF_STALL_CNT_EN
      hpm3_q      <= 64'h0;
`endif
    end else begin
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      inh_q       <= inh_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      illegal_q   <= illegal_d;
`ifdef PERF_STALL_CNT_EN
      hpm3_q      <= hpm3_d;
`endif
    end
  end

  assign csr_rsp_valid = rsp_valid_q;
  assign csr_rdata     = rdata_q;
  assign csr_illegal   = illegal_q;

endmodule

// File: doc/perf_csr_unit.md
Name: perf_csr_unit

Overview:
- Reads and writes the machine performance counters required by Zicntr/Zihpm.
- Consumes the retire indication produced at writeback; serves CSR instructions issued from EX.
- Holds the 64-bit cycle and instret counters and mcountinhibit.
- Answers each CSR access with a registered one-cycle response carrying read data or an illegal-access flag.

Parameters:
- CYCLE_RST, 64'h0, reset value of mcycle.
- INSTRET_RST, 64'h0, reset value of minstret.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- retire_valid  in  1  one instruction retired this cycle (MEM/WB valid)
- stall_cycle  in  1  pipeline stalled this cycle (used only with the optional feature)
- csr_req  in  1  CSR access request, single-cycle pulse
- csr_addr  in  12  CSR address
- csr_op  in  2  00 read, 01 write, 10 set, 11 clear
- csr_wdata  in  32  write / set / clear operand
- csr_kill  in  1  flush; cancels any side effect of the request in the same cycle
- csr_rsp_valid  out  1  response valid, exactly one cycle after an accepted csr_req
- csr_rdata  out  32  old CSR value (value before this access)
- csr_illegal  out  1  access faulted; sampled only when csr_rsp_valid=1

Behaviour:
- Reset (synchronous, active-high):
  - mcycle=CYCLE_RST, minstret=INSTRET_RST, mcountinhibit=0.
  - csr_rsp_valid=0, csr_rdata=0, csr_illegal=0.
- Counting:
  - mcycle +1 every cycle unless mcountinhibit[0]=1.
  - minstret +1 when retire_valid=1, unless mcountinhibit[2]=1.
  - Full 64-bit increment: carry from bit 31 to bit 32 in the same cycle; wraps from all-ones to 0.
- Address map:
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: RW.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: RO aliases.
  - mcountinhibit 0x320: RW; only bits 0 and 2 writable, all other bits read 0.
- Request accepted when csr_req=1 and csr_kill=0. On the next cycle:
  - csr_rsp_valid=1.
  - csr_rdata = value at the request cycle, before that cycle's increment or write.
- Write data by op:
  - write: new = wdata.
  - set: new = old | wdata.
  - clear: new = old & ~wdata.
  - set/clear with wdata=0 is a pure read and causes no write.
- Illegal access (csr_illegal=1, rdata=0, no state change):
  - unmapped address.
  - any write/set/clear with nonzero effect to 0xCxx.
- Write to a counter half:
  - The written half takes the new value.
  - That counter's increment is suppressed in that cycle, in both halves; the other half holds.
  - The next cycle resumes incrementing from the written value.
- Write to mcountinhibit takes effect from the cycle after the write.
- csr_req with csr_kill=1: not accepted; no response, no state change. Counting is unaffected.
- csr_rsp_valid is a single-cycle pulse. Back-to-back requests give back-to-back responses.
- Reset asserted mid-access: pending response dropped, csr_rsp_valid=0 the following cycle.

Optional Feature:
- Macro: PERF_STALL_CNT_EN.
- Defined:
  - Adds 64-bit mhpmcounter3 at 0xB03/0xB83 (RW) and hpmcounter3 at 0xC03/0xC83 (RO), reset 0.
  - Increments when stall_cycle=1 and mcountinhibit[3]=0; mcountinhibit[3] becomes writable.
  - Write, suppression and wrap rules same as mcycle.
- Undefined:
  - 0xB03/0xB83/0xC03/0xC83 read 0 and are not illegal; writes ignored.
  - mcountinhibit[3] reads 0; stall_cycle unused.

Test Plan:
- Reset, then idle 10 cycles, read 0xB00 at cycle 10 -> rsp next cycle rdata=10, illegal=0; 0xB80 reads 0.
- Write mcycle=32'hFFFF_FFFE, mcycleh=0, then read 0xB80 three cycles later -> rdata=1, confirming carry into high half.
- retire_valid high for 5 cycles, with mcountinhibit write 32'h4 issued at cycle 3 -> minstret final=4 (counts at cycles 0-3, inhibited from cycle 4).
- Write 0xC00 with wdata=5 -> illegal=1, rdata=0, cycle unchanged; set to 0xC00 with wdata=0 -> illegal=0, returns current count.
- csr_req write minstret=100 with csr_kill=1 -> no rsp_valid, minstret unchanged; same request with kill=0 and retire_valid=1 -> minstret=100 next cycle, then 101 after a further retire.
- Under PERF_STALL_CNT_EN: stall_cycle high 7 cycles, read 0xC03 -> 7. Without the macro: same read -> 0, illegal=0.
